seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each digit stays selected, >=2.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, >=1.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0: when 1, seg_out, dp_out and an_out are inverted at the output register.
REQ-005 clk  input  1  single system clock, rising-edge.
REQ-006 rst_n  input  1  asynchronous reset, active-low.
REQ-007 bcd_in  input  4*DIGITS  digit codes; nibble i = digit i; digit 0 is least significant.
REQ-008 dp_in  input  DIGITS  decimal point per digit.
REQ-009 blink_in  input  DIGITS  blink enable per digit.
REQ-010 load  input  1  capture strobe for bcd_in, dp_in and blink_in.
REQ-011 lz_en  input  1  leading-zero suppression enable, sampled live.
REQ-012 seg_out  output  7  segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-013 dp_out  output  1  decimal-point segment.
REQ-014 an_out  output  DIGITS  one-hot digit select.
REQ-015 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-016 Decode (active-high view): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex); codes 10..15 SHALL render dash 01.
REQ-017 Prescaler counts 0..SCAN_DIV-1 and wraps; at terminal count the digit index advances by 1, wrapping DIGITS-1 -> 0.
REQ-018 frame_done SHALL be 1 for exactly the cycle after an index wrap DIGITS-1 -> 0; 0 otherwise.
REQ-019 load=1 captures inputs into a shadow register and sets a pending flag; further loads overwrite the shadow.
REQ-020 Pending shadow is copied to the display register on an index wrap; the pending flag then clears; no tearing within a frame.
REQ-021 load coincident with an index wrap: the new data goes to the shadow and stays pending; the old shadow is not transferred; the new data transfers at the next wrap.
REQ-022 Leading-zero suppression: with lz_en=1, digit i (i>=1) SHALL be blanked when its code and every higher digit's code are 0; digit 0 is never suppressed; dp is unaffected.
REQ-023 Blink phase toggles every BLINK_FRAMES frame wraps; in phase 1, a digit with its display-register blink bit set SHALL show seg=00 and dp=0; an_out is unaffected.
REQ-024 seg_out, dp_out and an_out are registered: they reflect the digit index and display register with 1-cycle latency.
REQ-025 Exactly one an_out bit SHALL be active at any time after the first post-reset clock edge; no glitch across index changes.

Reset
REQ-026 rst_n=0 SHALL immediately clear the prescaler, index, display register, shadow, pending flag, blink phase and blink frame counter.
REQ-027 During reset, seg_out, dp_out and an_out SHALL be inactive (all 0 when SEG_ACTIVE_LOW=0; all 1 when 1), and frame_done=0.
REQ-028 At the first edge after rst_n rises, an_out SHALL select digit 0 showing "0" (7E); reset mid-scan aborts the frame and discards pending data.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, SEG_ACTIVE_LOW=0)
REQ-029 Reset release with idle inputs -> an_out sequence 0001,0010,0100,1000 at 4 cycles each, every digit seg=7E; frame_done pulses every 16 cycles.
REQ-030 Load bcd_in=0x9A21 mid-frame -> digits unchanged until the wrap; then seg 30,6D,01,7B on digits 0..3.
REQ-031 lz_en=1, load 0x0050 -> digit3 and digit2 seg=00, digit1=5B, digit0=7E; load 0x0000 -> only digit0 shows 7E.
REQ-032 Load blink_in=0010 with bcd 0x1234 -> digit1 alternates 79 / 00 every 2 frames; other digits steady.
REQ-033 load asserted on the wrap cycle -> display holds old data for one more frame, then updates.
REQ-034 rst_n pulsed low mid-digit with data pending -> outputs go inactive asynchronously; after release all digits show 7E.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: BCD decode, leading-zero suppression,
// per-digit blink, and frame-synchronous (tear-free) display updates.
module seven_seg_scanner #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic             INV      = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [BLK_W-1:0]    blk_cnt;
  logic                phase;
  logic                pend;
  logic [4*DIGITS-1:0] disp_bcd, sh_bcd;
  logic [DIGITS-1:0]   disp_dp, sh_dp, disp_blink, sh_blink;

  logic                tick_c, wrap_c;
  logic [3:0]          code_c;
  logic [DIGITS-1:0]   lz_mask_c;
  logic [6:0]          seg_c;
  logic                dp_c;
  logic [DIGITS-1:0]   an_c;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'h7E;
      4'd1:    decode = 7'h30;
      4'd2:    decode = 7'h6D;
      4'd3:    decode = 7'h79;
      4'd4:    decode = 7'h33;
      4'd5:    decode = 7'h5B;
      4'd6:    decode = 7'h5F;
      4'd7:    decode = 7'h70;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h7B;
      default: decode = 7'h01;
    endcase
  endfunction

  // Scan timing and the frame-wrap event
  always_comb begin
    tick_c = (cnt == CNT_LAST);
    wrap_c = tick_c && (idx == IDX_LAST);
  end

  // Digit i is suppressible when it and all higher digits are zero; digit 0 never
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask_c  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above && (disp_bcd[4*i +: 4] == 4'd0);
      lz_mask_c[i] = zero_above;
    end
  end

  // Next output values for the currently selected digit
  always_comb begin
    logic blank;
    logic blink_off;
    code_c    = disp_bcd[{idx, 2'b00} +: 4];
    blank     = lz_en && lz_mask_c[idx];
    blink_off = phase && disp_blink[idx];
    seg_c     = (blank || blink_off) ? 7'h00 : decode(code_c);
    dp_c      = blink_off ? 1'b0 : disp_dp[idx];
    an_c      = '0;
    an_c[idx] = 1'b1;
  end

  // Prescaler, digit index and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (wrap_c) begin
        if (blk_cnt == BLK_LAST) begin
          blk_cnt <= '0;
          phase   <= ~phase;
        end else begin
          blk_cnt <= blk_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Shadow capture; a load on the wrap cycle wins and defers the transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bcd     <= '0;
      sh_dp      <= '0;
      sh_blink   <= '0;
      disp_bcd   <= '0;
      disp_dp    <= '0;
      disp_blink <= '0;
      pend       <= 1'b0;
    end else if (load) begin
      sh_bcd   <= bcd_in;
      sh_dp    <= dp_in;
      sh_blink <= blink_in;
      pend     <= 1'b1;
    end else if (wrap_c && pend) begin
      disp_bcd   <= sh_bcd;
      disp_dp    <= sh_dp;
      disp_blink <= sh_blink;
      pend       <= 1'b0;
    end
  end

  // Output register with optional polarity inversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= {7{INV}};
      dp_out     <= INV;
      an_out     <= {DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_c ^ {7{INV}};
      dp_out     <= dp_c ^ INV;
      an_out     <= an_c ^ {DIGITS{INV}};
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: table vectors, corner sequences
// and randomized traffic against a cycle-count-based reference model.
module tb_seven_seg_scanner;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = SD * D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in, blink_in;
  logic        load, lz_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  seven_seg_scanner #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .blink_in(blink_in),
    .load(load), .lz_en(lz_en), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: n = edges since reset release; display/shadow at frame level
  int          n;
  logic [15:0] m_bcd, m_sh_bcd;
  logic [3:0]  m_dp, m_sh_dp, m_blk, m_sh_blk;
  bit          m_pend;
  logic [6:0]  seg_tab [16];

  typedef struct packed {
    logic [15:0]      bcd;
    logic             lz;
    logic [3:0][6:0]  exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_pend = 0;
    m_bcd = '0; m_dp = '0; m_blk = '0;
    m_sh_bcd = '0; m_sh_dp = '0; m_sh_blk = '0;
  endtask

  // One clock edge: predict, update model with this edge's inputs, compare
  task automatic tick();
    int nn, d;
    bit ph, blank, boff;
    logic [6:0] es;
    logic ed;
    logic [3:0] ea;
    nn    = n + 1;
    d     = ((nn - 1) / SD) % D;
    ph    = ((((nn - 1) / FR) / BF) % 2) == 1;
    blank = lz_en && d >= 1 && ((m_bcd >> (4 * d)) == 16'd0);
    boff  = ph && m_blk[d];
    es    = (blank || boff) ? 7'h00 : seg_tab[m_bcd[4*d +: 4]];
    ed    = boff ? 1'b0 : m_dp[d];
    ea    = 4'(1) << d;
    if ((nn % FR) == 0 && !load && m_pend) begin
      m_bcd = m_sh_bcd; m_dp = m_sh_dp; m_blk = m_sh_blk; m_pend = 0;
    end
    if (load) begin
      m_sh_bcd = bcd_in; m_sh_dp = dp_in; m_sh_blk = blink_in; m_pend = 1;
    end
    @(posedge clk);
    n = nn;
    #1;
    check("seg", 32'(seg_out), 32'(es));
    check("dp", 32'(dp_out), 32'(ed));
    check("an", 32'(an_out), 32'(ea));
    check("frame_done", 32'(frame_done), 32'((nn % FR) == 0));
  endtask

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
    vecs[0] = '{16'h9A21, 1'b0, {7'h7B, 7'h01, 7'h6D, 7'h30}};
    vecs[1] = '{16'h0050, 1'b1, {7'h00, 7'h00, 7'h5B, 7'h7E}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
    vecs[3] = '{16'h1234, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}};
    vecs[4] = '{16'h0000, 1'b0, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
    vecs[5] = '{16'hFEDC, 1'b0, {7'h01, 7'h01, 7'h01, 7'h01}};
    vecs[6] = '{16'h8765, 1'b1, {7'h7F, 7'h70, 7'h5F, 7'h5B}};
    vecs[7] = '{16'h0907, 1'b1, {7'h00, 7'h7B, 7'h7E, 7'h70}};

    rst_n = 1'b0; bcd_in = '0; dp_in = '0; blink_in = '0; load = 1'b0; lz_en = 1'b0;
    model_reset();
    #1;
    check("reset_seg", 32'(seg_out), 32'h0);
    check("reset_an", 32'(an_out), 32'h0);
    check("reset_fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Idle scan after reset: all digits show 0
    for (int k = 0; k < 2 * FR; k++) tick();

    // Table vectors: load, wait for the wrap transfer, then check one frame
    for (int v = 0; v < 8; v++) begin
      bcd_in = vecs[v].bcd; lz_en = vecs[v].lz; dp_in = '0; blink_in = '0; load = 1'b1;
      repeat (3) tick();
      load = 1'b0;
      for (int k = 0; k < 3 * FR && m_pend; k++) tick();
      for (int k = 0; k < FR; k++) begin
        int d;
        tick();
        d = ((n - 1) / SD) % D;
        check($sformatf("vec%0d_digit%0d", v, d), 32'(seg_out), 32'(vecs[v].exp[d]));
      end
    end

    // Load coincident with the wrap edge: old data held for one more frame
    lz_en = 1'b0;
    while (((n + 1) % FR) != 0) tick();
    bcd_in = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    begin
      int w;
      w = n;
      tick();
      check("wrap_load_hold", 32'(seg_out), 32'h70);
      while (n < w + FR + 1) tick();
      check("wrap_load_update", 32'(seg_out), 32'h30);
    end

    // Blink on digit 1 across several blink half-periods
    bcd_in = 16'h1234; blink_in = 4'b0010; dp_in = 4'b1010; load = 1'b1;
    tick();
    load = 1'b0; blink_in = '0; dp_in = '0;
    for (int k = 0; k < 8 * FR; k++) tick();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [15:0] mask;
      case ($urandom_range(3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      load     = ($urandom_range(9) == 0);
      bcd_in   = 16'($urandom) & mask;
      dp_in    = 4'($urandom);
      blink_in = 4'($urandom);
      if ($urandom_range(15) == 0) lz_en = ~lz_en;
      tick();
    end
    load = 1'b0;

    // Asynchronous reset mid-digit with data pending
    bcd_in = 16'h5555; dp_in = 4'hF; load = 1'b1;
    while ((n % SD) != 1) tick();
    tick();
    load = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg_out), 32'h0);
    check("async_rst_dp", 32'(dp_out), 32'h0);
    check("async_rst_an", 32'(an_out), 32'h0);
    check("async_rst_fd", 32'(frame_done), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 2 * FR; k++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
